squid_rs_encoder: RTL and testbench
===================================

# squid_rs_encoder

Streaming systematic Reed-Solomon encoder over GF(16) with primitive polynomial x^4+x+1 and α = 2. It is the transmit-side counterpart of the SQUID decoder. It accepts K data symbols per codeword, passes them through unchanged, then appends two parity symbols from generator g(x) = (x+α)(x+α²) = x² + 6x + 8. The decoder's syndromes S1 = c(α) and S2 = c(α²) are therefore zero for every error-free codeword it emits.

## Interface
Parameters:
- K, default 13: data symbols per codeword. Legal range 1..13, so that N = K+2 ≤ 15.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- rst_n, input, 1: reset. One clock; reset is synchronous and active-low.
- in_valid, input, 1: a data symbol is presented on in_data.
- in_data, input, 4: data symbol, MSB-first polynomial order (first symbol is the highest-degree coefficient).
- in_ready, output, 1: encoder accepts in_data this cycle.
- out_valid, output, 1: out_data holds a codeword symbol.
- out_data, output, 4: codeword symbol. Order is the K data symbols, then p1, then p0.
- out_last, output, 1: qualifies out_valid. It is high on p0, the final symbol of the codeword.
- out_ready, input, 1: downstream accepts out_data this cycle.
- busy, output, 1: a codeword is in progress (at least one data symbol accepted, p0 not yet handed off).

## Operation
- GF multiply by constants 6 and 8 is implemented as XOR networks (GFMULT-compatible arithmetic). There is no carry, and every operand is 4 bits.
- Parity LFSR registers r1 and r0 (4 bits each). On each accepted data symbol d:
  - fb = d ^ r1
  - r1 ← r0 ^ (fb·6)
  - r0 ← fb·8
- A data counter cnt runs 0..K-1.
- The output stage is a single register: out_data, out_valid and out_last. "Slot free" means !out_valid || out_ready.
- FSM states:
  - DATA (reset state). in_ready = slot free. On in_valid && in_ready:
    - out_data ← in_data, out_valid ← 1, out_last ← 0.
    - Update the LFSR; cnt increments.
    - When cnt = K-1, go to PAR1 and clear cnt.
  - PAR1. in_ready = 0. When the slot is free: out_data ← r1 (as already updated), out_valid ← 1, out_last ← 0. Go to PAR0.
  - PAR0. in_ready = 0. When the slot is free: out_data ← r0, out_valid ← 1, out_last ← 1. Clear r1 and r0 to 0. Go to DATA.
- When the slot is free and nothing is loaded, out_valid ← 0.
- Out data holds stable while out_valid && !out_ready (standard valid/ready; no combinational path from out_ready to out_data).
- busy = (state ≠ DATA) || (cnt ≠ 0) || (out_valid && !out_last_handed_off). In practice: high from the first data acceptance until the cycle p0 is accepted downstream.

## Timing
- Reset values:
  - in_ready = 0 during reset, 1 from the first cycle after reset.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - state = DATA, cnt = 0, r1 = r0 = 0.
- Reset mid-codeword discards the partial codeword, including any pending out_valid. The next accepted symbol starts a fresh codeword.
- Latency: a symbol accepted at edge t is visible on out_data after edge t (one-cycle register).
- With out_ready held high, throughput is one symbol per cycle:
  - K data symbols are accepted over K cycles.
  - p1 is presented on the next cycle and p0 on the one after.
  - in_ready is low for exactly those 2 cycles.
  - Back-to-back codewords use K+2 cycles each, with no bubbles.
- in_ready depends on out_ready combinationally (slot free). It never depends on in_valid.
- When out_ready is low with out_valid high, nothing advances: no LFSR update, no counter change, no state change.
- K = 1 is legal: state goes DATA → PAR1 after a single acceptance.

## Test plan
- Reset, then K = 2, out_ready = 1, data 1, 0 → out sequence 1, 0, 15, 5. out_last is high only on 5.
- K = 2, data 0, 1 → out 0, 1, 6, 8 (equals g(x)). Then immediately data 1, 0 → 1, 0, 15, 5. Both codewords go back-to-back with no idle cycle, and r1/r0 clear between them.
- K = 13, random data, random out_ready and in_valid stalls → output data equals input data in order.
  - For each codeword, c(α) = 0 and c(α²) = 0 via a reference GF model.
  - out_data is stable during every stall.
- K = 13, all-zero data → parity 0, 0. All-0xF data → parity matches the model and both syndromes are zero.
- Assert rst_n low after 5 data symbols, release, then send a full codeword.
  - No stale out_valid.
  - The new codeword's parity ignores the 5 pre-reset symbols.
  - busy = 0 right after reset.
- in_valid held high throughout PAR1/PAR0 → in_ready is 0 for exactly 2 cycles, no symbol is dropped or duplicated, and the next symbol begins the next codeword.

Source files
------------

// File: rtl/squid_rs_encoder.sv
// squid_rs_encoder
// ----------------
// Streaming systematic Reed-Solomon encoder over GF(16).
// The field uses x^4+x+1 with alpha = 2, and the generator is
// g(x) = (x+a)(x+a^2) = x^2 + 6x + 8.
// Each codeword is K data symbols, passed through unchanged, followed by the
// two parity symbols p1 and p0. A receiver computing S1 = c(a) and S2 = c(a^2)
// over any codeword produced here sees zero for both.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data carries a data symbol
//   in_data    : data symbol, highest-degree coefficient first
//   in_ready   : encoder takes in_data this cycle
//   out_valid  : out_data carries a codeword symbol
//   out_data   : codeword symbol (K data, then p1, then p0)
//   out_last   : high with out_valid on p0
//   out_ready  : downstream takes out_data this cycle
//   busy       : a codeword is in flight (first data accepted .. p0 handed off)

module squid_rs_encoder #(
  parameter int K = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAR1 = 2'd1,
    S_PAR0 = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(K - 1);

  // Multiply by alpha: shift left, and fold x^4 back in as x+1.
  function automatic logic [3:0] gf_x2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  // 6 = alpha^2 + alpha, so the product is the XOR of both scaled copies.
  function automatic logic [3:0] gf_x6(input logic [3:0] a);
    return gf_x2(gf_x2(a)) ^ gf_x2(a);
  endfunction

  // 8 = alpha^3.
  function automatic logic [3:0] gf_x8(input logic [3:0] a);
    return gf_x2(gf_x2(gf_x2(a)));
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] r1_q, r1_d;
  logic [3:0] r0_q, r0_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;

  logic       slot_free;
  logic       accept;
  logic [3:0] fb;

  // The output register can take a new symbol when it is empty or being
  // drained this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Held low while reset is asserted so nothing is offered before the
  // registers hold known values.
  assign in_ready  = rst_n && (state_q == S_DATA) && slot_free;
  assign accept    = in_valid && in_ready;

  assign fb        = in_data ^ r1_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // A loaded-but-not-taken p0 keeps busy high after the FSM has returned to
  // DATA with the counter cleared.
  assign busy = (state_q != S_DATA) || (cnt_q != 4'd0) ||
                (out_valid_q && out_last_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r1_d       = r1_q;
    r0_d       = r0_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;

    if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          r1_d        = r0_q ^ gf_x6(fb);
          r0_d        = gf_x8(fb);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = 4'd0;
            state_d = S_PAR1;
          end else begin
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end
      S_PAR1: begin
        if (slot_free) begin
          out_data_d  = r1_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = S_PAR0;
        end
      end
      S_PAR0: begin
        if (slot_free) begin
          out_data_d  = r0_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          // Clear here so the next codeword starts from a zero remainder
          // even when it is accepted on the very next cycle.
          r1_d        = 4'd0;
          r0_d        = 4'd0;
          state_d     = S_DATA;
        end
      end
      default: begin
        state_d = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      cnt_q       <= 4'd0;
      r1_q        <= 4'd0;
      r0_q        <= 4'd0;
      out_data_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r1_q        <= r1_d;
      r0_q        <= r0_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_squid_rs_encoder.sv
module tb_squid_rs_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [3:0] in_data   [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [3:0] out_data  [2];
  logic       out_last  [2];
  logic [1:0] out_ready;
  logic       busy      [2];

  int tot = 0;
  int bad = 0;

  logic [4:0] q0 [$];
  logic [4:0] q1 [$];
  logic [1:0] rand_rdy = 2'b00;
  logic [3:0] msg [13];

  logic [3:0] acc1 [2];
  logic [3:0] acc2 [2];
  logic       hold_v [2];
  logic [4:0] hold_e [2];

  always #5 clk = ~clk;

  squid_rs_encoder #(.K(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .out_ready(out_ready[0]), .busy(busy[0]));

  squid_rs_encoder #(.K(13)) u_k13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .out_ready(out_ready[1]), .busy(busy[1]));

  // Reference GF(16) multiply: shift-and-add with reduction by x^4+x+1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r = 4'd0;
    logic [3:0] t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = t[3] ? ({t[2:0], 1'b0} ^ 4'b0011) : {t[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [4:0] e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Random downstream back-pressure, changed only just after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      out_ready[i] = rand_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  // and evaluates both syndromes over each completed codeword.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [3:0] sym;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        acc1[i] = 4'd0; acc2[i] = 4'd0; hold_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hold_v[i]) begin
          tot++;
          if (!(out_valid[i] && {out_last[i], out_data[i]} == hold_e[i])) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got v=%0d d=%0d l=%0d expected d=%0d l=%0d",
                     i, out_valid[i], out_data[i], out_last[i], hold_e[i][3:0], hold_e[i][4]);
          end
        end
        if (out_valid[i] && out_ready[i]) begin
          hold_v[i] = 1'b0;
          sym = out_data[i];
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            tot++; bad++;
            $display("FAIL unexpected_out[%0d]: got d=%0d expected nothing", i, sym);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("out_data[%0d]", i), int'(sym), int'(e[3:0]));
            chk($sformatf("out_last[%0d]", i), int'(out_last[i]), int'(e[4]));
            acc1[i] = gf_mul(acc1[i], 4'd2) ^ sym;
            acc2[i] = gf_mul(acc2[i], 4'd4) ^ sym;
            if (out_last[i]) begin
              chk($sformatf("synd1[%0d]", i), int'(acc1[i]), 0);
              chk($sformatf("synd2[%0d]", i), int'(acc2[i]), 0);
              acc1[i] = 4'd0; acc2[i] = 4'd0;
            end
          end
        end else if (out_valid[i]) begin
          hold_v[i] = 1'b1;
          hold_e[i] = {out_last[i], out_data[i]};
        end else begin
          hold_v[i] = 1'b0;
        end
      end
    end
  end

  // Present one symbol and hold it until the encoder takes it. Returns just
  // after the accepting edge with in_valid still high.
  task automatic send(input int i, input logic [3:0] d, output int waits);
    waits = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    forever begin
      @(negedge clk);
      if (in_ready[i]) break;
      waits++;
      if (waits > 200) begin
        tot++; bad++;
        $display("FAIL accept_timeout[%0d]: got no in_ready expected within 200 cycles", i);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Long division of msg(x)*x^2 by g(x) to produce the expected parity.
  task automatic model_parity(input int k, output logic [3:0] p1, output logic [3:0] p0);
    logic [3:0] c [15];
    for (int j = 0; j < 15; j++) c[j] = (j < k) ? msg[j] : 4'd0;
    for (int j = 0; j < k; j++) begin
      c[j + 1] = c[j + 1] ^ gf_mul(c[j], 4'd6);
      c[j + 2] = c[j + 2] ^ gf_mul(c[j], 4'd8);
    end
    p1 = c[k];
    p0 = c[k + 1];
  endtask

  task automatic run_cw(input int i, input int k, input bit stall, output int w0);
    logic [3:0] p1, p0;
    int w;
    w0 = 0;
    model_parity(k, p1, p0);
    for (int j = 0; j < k; j++) push_exp(i, {1'b0, msg[j]});
    push_exp(i, {1'b0, p1});
    push_exp(i, {1'b1, p0});
    for (int j = 0; j < k; j++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        in_valid[i] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(i, msg[j], w);
      if (j == 0) w0 = w;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < 500) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    in_valid = 2'b00;
    in_data[0] = 4'd0; in_data[1] = 4'd0;
    out_ready = 2'b11;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), int'(in_ready[i]), 0);
      chk($sformatf("rst_out_valid[%0d]", i), int'(out_valid[i]), 0);
      chk($sformatf("rst_out_data[%0d]", i), int'(out_data[i]), 0);
      chk($sformatf("rst_out_last[%0d]", i), int'(out_last[i]), 0);
      chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready0", int'(in_ready[0]), 1);
    chk("post_rst_in_ready1", int'(in_ready[1]), 1);
    @(posedge clk); #1;

    // K=2, data 1,0 -> 1,0,15,5
    push_exp(0, {1'b0, 4'd1}); push_exp(0, {1'b0, 4'd0});
    push_exp(0, {1'b0, 4'd15}); push_exp(0, {1'b1, 4'd5});
    send(0, 4'd1, w);
    chk("busy_after_first", int'(busy[0]), 1);
    send(0, 4'd0, w);
    in_valid[0] = 1'b0;
    drain();
    chk("busy_idle_k2", int'(busy[0]), 0);

    // K=2 back-to-back: 0,1 -> 0,1,6,8 then 1,0 -> 1,0,15,5
    push_exp(0, {1'b0, 4'd0}); push_exp(0, {1'b0, 4'd1});
    push_exp(0, {1'b0, 4'd6}); push_exp(0, {1'b1, 4'd8});
    push_exp(0, {1'b0, 4'd1}); push_exp(0, {1'b0, 4'd0});
    push_exp(0, {1'b0, 4'd15}); push_exp(0, {1'b1, 4'd5});
    send(0, 4'd0, w);
    send(0, 4'd1, w);
    chk("b2b_k2_data_wait", w, 0);
    send(0, 4'd1, w);
    chk("b2b_k2_parity_gap", w, 2);
    send(0, 4'd0, w);
    chk("b2b_k2_second_wait", w, 0);
    in_valid[0] = 1'b0;
    drain();

    // K=13 random data with back-pressure and input gaps
    rand_rdy[1] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 13; j++) msg[j] = 4'($urandom_range(0, 15));
      run_cw(1, 13, 1'b1, w);
      in_valid[1] = 1'b0;
    end
    drain();
    rand_rdy[1] = 1'b0;
    @(posedge clk); #1;

    // All-zero and all-0xF codewords
    for (int j = 0; j < 13; j++) msg[j] = 4'd0;
    run_cw(1, 13, 1'b0, w);
    for (int j = 0; j < 13; j++) msg[j] = 4'hF;
    run_cw(1, 13, 1'b0, w);
    in_valid[1] = 1'b0;
    drain();
    chk("busy_idle_k13", int'(busy[1]), 0);

    // Reset after 5 data symbols of a K=13 codeword
    for (int j = 0; j < 5; j++) begin
      push_exp(1, {1'b0, 4'(j + 3)});
      send(1, 4'(j + 3), w);
    end
    in_valid[1] = 1'b0;
    rst_n = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", int'(out_valid[1]), 0);
    chk("after_rst_busy", int'(busy[1]), 0);
    chk("after_rst_in_ready", int'(in_ready[1]), 1);
    @(posedge clk); #1;
    for (int j = 0; j < 13; j++) msg[j] = 4'(12 - j);
    run_cw(1, 13, 1'b0, w);
    in_valid[1] = 1'b0;
    drain();

    // K=13 back-to-back with in_valid held through both parity cycles
    for (int j = 0; j < 13; j++) msg[j] = 4'(j + 1);
    run_cw(1, 13, 1'b0, w);
    for (int j = 0; j < 13; j++) msg[j] = 4'($urandom_range(0, 15));
    run_cw(1, 13, 1'b0, w);
    chk("b2b_k13_parity_gap", w, 2);
    in_valid[1] = 1'b0;
    drain();
    chk("final_busy1", int'(busy[1]), 0);
    chk("final_out_valid1", int'(out_valid[1]), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
